// File: rtl/dart_pkg.sv
// rtl/dart_pkg.sv - shared types, tables and constants for the darts scoring controller
package dart_pkg;

   localparam int PT_W    = 9;
   localparam int SCORE_W = 6;
   localparam int R2_W    = 17;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCORE,
      S_UPDATE,
      S_ACK,
      S_OVER
   } state_t;

   // Sector value per octant (2*quadrant + half)
   localparam logic [SCORE_W-1:0] SECTOR_VAL [0:7] = '{
      6'd20, 6'd1, 6'd18, 6'd4, 6'd13, 6'd6, 6'd10, 6'd15
   };

   // Ring boundaries on squared radius, inclusive
   localparam logic [R2_W-1:0] R2_BULL       = 17'd1;
   localparam logic [R2_W-1:0] R2_OUTER_BULL = 17'd4;
   localparam logic [R2_W-1:0] R2_SINGLE_IN  = 17'd36;
   localparam logic [R2_W-1:0] R2_TRIPLE     = 17'd64;
   localparam logic [R2_W-1:0] R2_SINGLE_OUT = 17'd144;
   localparam logic [R2_W-1:0] R2_DOUBLE     = 17'd196;

   localparam logic [SCORE_W-1:0] BULL_VAL       = 6'd50;
   localparam logic [SCORE_W-1:0] OUTER_BULL_VAL = 6'd25;

endpackage

// File: rtl/dart_game_ctrl_if.sv
// rtl/dart_game_ctrl_if.sv - dart stimulus and score status bundle
interface dart_game_ctrl_if;
   import dart_pkg::*;

   logic              dart_come_i;
   logic [7:0]        dart_position_x_i;
   logic [7:0]        dart_position_y_i;
   logic              game_set_o;
   logic              player_1_done_o;
   logic              player_2_done_o;
   logic              player_1_win_o;
   logic              player_2_win_o;
   logic [PT_W-1:0]   player_1_pt_o;
   logic [PT_W-1:0]   player_2_pt_o;

   modport slave (
      input  dart_come_i, dart_position_x_i, dart_position_y_i,
      output game_set_o, player_1_done_o, player_2_done_o,
             player_1_win_o, player_2_win_o, player_1_pt_o, player_2_pt_o
   );

   modport master (
      output dart_come_i, dart_position_x_i, dart_position_y_i,
      input  game_set_o, player_1_done_o, player_2_done_o,
             player_1_win_o, player_2_win_o, player_1_pt_o, player_2_pt_o
   );

endinterface

// File: rtl/dart_score_lut.sv
// rtl/dart_score_lut.sv - combinational board coordinate to dart score
module dart_score_lut
   import dart_pkg::*;
#(
   parameter int CX = 15,
   parameter int CY = 15
) (
   input  logic [7:0]         i_x,
   input  logic [7:0]         i_y,
   output logic [SCORE_W-1:0] o_score
);

   // Offsets kept as raw 9-bit two's complement; bit 8 is the sign
   logic [8:0]         w_dx;
   logic [8:0]         w_dy;
   logic [8:0]         w_adx;
   logic [8:0]         w_ady;
   logic [R2_W-1:0]    w_r2;
   logic [2:0]         w_octant;
   logic [SCORE_W-1:0] w_sector;
   logic [SCORE_W-1:0] w_double;
   logic [SCORE_W-1:0] w_triple;

   assign w_dx  = {1'b0, i_x} - 9'(CX);
   assign w_dy  = {1'b0, i_y} - 9'(CY);
   assign w_adx = w_dx[8] ? (~w_dx + 9'd1) : w_dx;
   assign w_ady = w_dy[8] ? (~w_dy + 9'd1) : w_dy;
   assign w_r2  = ({8'd0, w_adx} * {8'd0, w_adx}) + ({8'd0, w_ady} * {8'd0, w_ady});

   // Quadrant bits {dy<0, dx<0 xor dy<0}, then the half within it
   assign w_octant = {w_dy[8], w_dx[8] ^ w_dy[8], (w_adx < w_ady)};
   assign w_sector = SECTOR_VAL[w_octant];
   assign w_double = w_sector << 1;
   assign w_triple = w_double + w_sector;

   // Pick the ring multiplier from the squared radius, innermost first
   always_comb begin
      o_score = '0;
      if (w_r2 <= R2_BULL)            o_score = BULL_VAL;
      else if (w_r2 <= R2_OUTER_BULL) o_score = OUTER_BULL_VAL;
      else if (w_r2 <= R2_SINGLE_IN)  o_score = w_sector;
      else if (w_r2 <= R2_TRIPLE)     o_score = w_triple;
      else if (w_r2 <= R2_SINGLE_OUT) o_score = w_sector;
      else if (w_r2 <= R2_DOUBLE)     o_score = w_double;
      else                            o_score = '0;
   end

endmodule

// File: rtl/dart_game_ctrl.sv
// rtl/dart_game_ctrl.sv - two-player countdown darts scoring and turn controller
module dart_game_ctrl
   import dart_pkg::*;
#(
   parameter int START_PT       = 301,
   parameter int CX             = 15,
   parameter int CY             = 15,
   parameter int DARTS_PER_TURN = 3
) (
   input logic              clk,
   input logic              reset,
   dart_game_ctrl_if.slave  bus
);

   localparam int CNT_W = (DARTS_PER_TURN > 1) ? $clog2(DARTS_PER_TURN) : 1;
   localparam logic [CNT_W-1:0] LAST_DART = CNT_W'(DARTS_PER_TURN - 1);
   localparam logic [PT_W-1:0]  START_VAL = PT_W'(START_PT);

   state_t              r_state;
   state_t              w_next_state;
   logic [7:0]          r_x;
   logic [7:0]          r_y;
   logic [SCORE_W-1:0]  r_score;
   logic [SCORE_W-1:0]  w_lut_score;
   logic [PT_W-1:0]     r_pt1;
   logic [PT_W-1:0]     r_pt2;
   logic [PT_W-1:0]     r_turn_start_pt;
   logic                r_cur_p2;
   logic [CNT_W-1:0]    r_dart_cnt;
   logic                r_done1;
   logic                r_done2;
   logic                r_win1;
   logic                r_win2;
   logic                r_game_set;

   logic [PT_W-1:0]     w_cur_pt;
   logic [PT_W-1:0]     w_oth_pt;
   logic signed [9:0]   w_rem;
   logic                w_bust;
   logic                w_win;
   logic                w_accept;

   dart_score_lut #(
      .CX (CX),
      .CY (CY)
   ) u_score (
      .i_x     (r_x),
      .i_y     (r_y),
      .o_score (w_lut_score)
   );

   assign w_cur_pt = r_cur_p2 ? r_pt2 : r_pt1;
   assign w_oth_pt = r_cur_p2 ? r_pt1 : r_pt2;
   assign w_rem    = $signed({1'b0, w_cur_pt}) - $signed({4'b0, r_score});
   assign w_bust   = w_rem[9];
   assign w_win    = (w_rem == 10'sd0);
   assign w_accept = bus.dart_come_i && !r_game_set;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Next-state: one dart walks IDLE->SCORE->UPDATE->ACK, a win parks in OVER
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_next_state = S_SCORE;
         S_SCORE:  w_next_state = S_UPDATE;
         S_UPDATE: w_next_state = w_win ? S_OVER : S_ACK;
         S_ACK:    w_next_state = S_IDLE;
         S_OVER:   w_next_state = S_OVER;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Datapath: latch position, register score, then apply it to the thrower
   always_ff @(posedge clk) begin
      if (reset) begin
         r_x             <= '0;
         r_y             <= '0;
         r_score         <= '0;
         r_pt1           <= START_VAL;
         r_pt2           <= START_VAL;
         r_turn_start_pt <= START_VAL;
         r_cur_p2        <= 1'b0;
         r_dart_cnt      <= '0;
         r_done1         <= 1'b0;
         r_done2         <= 1'b0;
         r_win1          <= 1'b0;
         r_win2          <= 1'b0;
         r_game_set      <= 1'b0;
      end else begin
         r_done1 <= 1'b0;
         r_done2 <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_x <= bus.dart_position_x_i;
                  r_y <= bus.dart_position_y_i;
               end
            end
            S_SCORE: r_score <= w_lut_score;
            S_UPDATE: begin
               if (r_cur_p2) r_done2 <= 1'b1;
               else          r_done1 <= 1'b1;
               if (w_bust) begin
                  // Undo the whole turn and hand over
                  if (r_cur_p2) r_pt2 <= r_turn_start_pt;
                  else          r_pt1 <= r_turn_start_pt;
                  r_cur_p2        <= ~r_cur_p2;
                  r_dart_cnt      <= '0;
                  r_turn_start_pt <= w_oth_pt;
               end else if (w_win) begin
                  if (r_cur_p2) begin
                     r_pt2  <= '0;
                     r_win2 <= 1'b1;
                  end else begin
                     r_pt1  <= '0;
                     r_win1 <= 1'b1;
                  end
                  r_game_set <= 1'b1;
               end else begin
                  if (r_cur_p2) r_pt2 <= w_rem[PT_W-1:0];
                  else          r_pt1 <= w_rem[PT_W-1:0];
                  if (r_dart_cnt == LAST_DART) begin
                     r_cur_p2        <= ~r_cur_p2;
                     r_dart_cnt      <= '0;
                     r_turn_start_pt <= w_oth_pt;
                  end else begin
                     r_dart_cnt <= r_dart_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.game_set_o      = r_game_set;
   assign bus.player_1_done_o = r_done1;
   assign bus.player_2_done_o = r_done2;
   assign bus.player_1_win_o  = r_win1;
   assign bus.player_2_win_o  = r_win2;
   assign bus.player_1_pt_o   = r_pt1;
   assign bus.player_2_pt_o   = r_pt2;

endmodule

// File: doc/dart_game_ctrl.md
Name: dart_game_ctrl

Overview:
Scoring and turn controller for the two-player countdown darts game; it is the design-under-test end of the dart stimulus interface. It samples each dart position on the `dart_come_i` handshake and converts the board coordinate to a score. It then updates the current player's remaining points, handles bust and turn rotation, and reports done, win and game-set status. It sits between the dart sensor front end (or the stimulus pattern) and the score display.

Parameters:
- START_PT, 301, initial points per player (9-bit range, ≤511).
- CX, 15, board centre x coordinate.
- CY, 15, board centre y coordinate.
- DARTS_PER_TURN, 3, darts thrown before the turn passes to the other player.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- dart_come_i  in  1  dart-present level. May stay high across darts.
- dart_position_x_i  in  8  dart x coordinate, unsigned.
- dart_position_y_i  in  8  dart y coordinate, unsigned.
- game_set_o  out  1  high once a player wins; held until reset.
- player_1_done_o  out  1  one-cycle pulse when a player-1 dart has been processed.
- player_2_done_o  out  1  one-cycle pulse when a player-2 dart has been processed.
- player_1_win_o  out  1  player 1 reached exactly 0; held until reset.
- player_2_win_o  out  1  player 2 reached exactly 0; held until reset.
- player_1_pt_o  out  9  player 1 remaining points.
- player_2_pt_o  out  9  player 2 remaining points.

Behaviour:
- Reset (synchronous, active-high, clk edge):
  - FSM goes to S_IDLE.
  - Both points are set to START_PT.
  - All flags and done pulses are cleared.
  - Current player = 1, dart_cnt = 0, turn_start_pt = START_PT.
  - Reset mid-operation aborts any in-flight dart with no done pulse.
- FSM states: S_IDLE, S_SCORE, S_UPDATE, S_ACK, S_OVER.
  - S_IDLE: if dart_come_i=1 and game not set, latch x/y and go to S_SCORE. Otherwise stay.
  - S_SCORE: register the scorer output (0..60) and go to S_UPDATE.
  - S_UPDATE: apply the score, assert the current player's done, then go to S_ACK, or S_OVER on a win.
  - S_ACK: deassert done and go to S_IDLE. This gives the source one full cycle to present the next position.
  - S_OVER: done deasserted, game_set_o=1. All dart_come_i is ignored until reset.
- Latency: x/y sampled at edge k. Points and done update at edge k+2. Done is high for exactly one cycle. The next sample is at edge k+4 at the earliest.
- Scoring (combinational, in the sub-module):
  - dx = x−CX and dy = y−CY, each signed 9 bits. r2 = dx²+dy², unsigned 17 bits.
  - Rings by r2:
    - r2≤1: bull, 50.
    - r2≤4: outer bull, 25.
    - r2≤36: single.
    - r2≤64: triple.
    - r2≤144: single.
    - r2≤196: double.
    - otherwise: miss, 0.
  - Quadrant q:
    - dx≥0, dy≥0 → 0.
    - dx<0, dy≥0 → 1.
    - dx<0, dy<0 → 2.
    - dx≥0, dy<0 → 3.
  - Half h = 0 if |dx|≥|dy|, else 1. Octant = 2q+h.
  - Sector value table, octant 0..7: 20, 1, 18, 4, 13, 6, 10, 15.
- Update with rem = cur_pt − score, computed in 10-bit signed:
  - rem<0 (bust): restore cur_pt to turn_start_pt, pass the turn to the other player, dart_cnt=0. The done pulse is still asserted for the busting player.
  - rem=0 (win): cur_pt=0, set the player's win flag and game_set_o. Done is pulsed.
  - rem>0: cur_pt=rem and dart_cnt++. When dart_cnt reaches DARTS_PER_TURN, pass the turn and set dart_cnt=0.
  - On every turn change, turn_start_pt is loaded with the incoming player's points.
- A miss (score 0) counts as a dart.
- Only one dart is in flight at a time. x/y changes outside S_IDLE have no effect.

Decomposition:
- Package dart_pkg holds:
  - State enum.
  - SECTOR_VAL[0:7] table.
  - Ring r2 thresholds.
  - Bull values 50 and 25.
  - Point width 9.
- One sub-module, dart_score_lut: combinational (x, y, CX, CY) → score[5:0]. It is verified standalone.

Test Plan:
1. Reset held for 5 cycles → both pt=301, game_set_o/win/done all 0; release reset, dart_come_i=0 for 10 cycles → no done pulse.
2. Scorer: (15,15)→50, (20,15)→20, (15,20)→1, (22,15)→60, (28,15)→40, (30,15)→0; each is checked via the point decrement from 301.
3. Player 1 throws (22,15) three times → three player_1_done_o one-cycle pulses, player_1_pt_o=121; the next dart pulses player_2_done_o.
4. With START_PT=50, player 1 throws (22,15) → bust: player_1_pt_o stays 50 and the next dart is credited to player 2.
5. With START_PT=50, player 1 throws (15,15) → player_1_pt_o=0, player_1_win_o=1, game_set_o=1; further darts with dart_come_i held high give no done pulses and no point changes.
6. Assert reset during S_SCORE → no done pulse, points=START_PT, and the next dart is credited to player 1.
